// File: rtl/muxnxn_rr.sv
// muxnxn_rr: N-channel, M-bit registered multiplexer with per-channel
// valid/ready handshake and a single output register with backpressure.
//
// Selection modes:
//   mode = 0 : round-robin; the search starts at ptr and wraps modulo N,
//              ptr moves to one past the granted channel after each transfer.
//   mode = 1 : fixed; channel sel is granted when it is valid. An index
//              sel >= N (non-power-of-two N) never matches any channel.
//
// Ports:
//   muxnxn_port_clk        clock, rising edge
//   muxnxn_port_rst        synchronous reset, active-high
//   muxnxn_port_i          packed channel data, channel k at [k*M +: M]
//   muxnxn_port_valid      per-channel valid
//   muxnxn_port_ready      per-channel ready (combinational, one-hot or zero)
//   muxnxn_port_mode       0 = round-robin, 1 = fixed select
//   muxnxn_port_sel        channel index used in fixed mode
//   muxnxn_port_out        registered output word
//   muxnxn_port_out_valid  output register holds a word
//   muxnxn_port_out_ready  downstream accepts the word this cycle
//   muxnxn_port_grant      channel index of the word in the output register

module muxnxn_rr #(
  parameter  int M  = 16,
  parameter  int N  = 4,
  localparam int SW = $clog2(N)
) (
  input  logic            muxnxn_port_clk,
  input  logic            muxnxn_port_rst,
  input  logic [N*M-1:0]  muxnxn_port_i,
  input  logic [N-1:0]    muxnxn_port_valid,
  output logic [N-1:0]    muxnxn_port_ready,
  input  logic            muxnxn_port_mode,
  input  logic [SW-1:0]   muxnxn_port_sel,
  output logic [M-1:0]    muxnxn_port_out,
  output logic            muxnxn_port_out_valid,
  input  logic            muxnxn_port_out_ready,
  output logic [SW-1:0]   muxnxn_port_grant
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] cand;
  logic          cand_found;
  logic          load_en;
  logic          xfer;
  logic [N-1:0]  rot;
  logic [M-1:0]  cand_word;
  logic [SW-1:0] ptr_next;
  int            idx;

  // The output register can take a word when empty or draining this cycle.
  assign load_en = !muxnxn_port_out_valid || muxnxn_port_out_ready;

  // Candidate selection. In round-robin the valid vector is rotated so that
  // bit 0 corresponds to channel ptr; the first set bit is the winner.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    idx        = 0;
    rot        = N'({muxnxn_port_valid, muxnxn_port_valid} >> ptr);
    if (muxnxn_port_mode) begin
      for (int k = 0; k < N; k++) begin
        if (muxnxn_port_sel == SW'(k) && muxnxn_port_valid[k]) begin
          cand       = SW'(k);
          cand_found = 1'b1;
        end
      end
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!cand_found && rot[j]) begin
          idx = int'(ptr) + j;
          if (idx >= N) idx = idx - N;
          cand       = SW'(idx);
          cand_found = 1'b1;
        end
      end
    end
  end

  // Ready is forced low during reset so no producer sees a handshake that
  // the reset is about to discard.
  always_comb begin
    muxnxn_port_ready = '0;
    for (int k = 0; k < N; k++) begin
      if (!muxnxn_port_rst && load_en && cand_found && cand == SW'(k))
        muxnxn_port_ready[k] = 1'b1;
    end
  end

  always_comb begin
    cand_word = '0;
    for (int k = 0; k < N; k++) begin
      if (cand == SW'(k)) cand_word = muxnxn_port_i[k*M +: M];
    end
  end

  assign xfer     = cand_found && load_en;
  assign ptr_next = (cand == SW'(N-1)) ? '0 : cand + SW'(1);

  always_ff @(posedge muxnxn_port_clk) begin
    if (muxnxn_port_rst) begin
      muxnxn_port_out       <= '0;
      muxnxn_port_out_valid <= 1'b0;
      muxnxn_port_grant     <= '0;
      ptr                   <= '0;
    end else if (xfer) begin
      muxnxn_port_out       <= cand_word;
      muxnxn_port_grant     <= cand;
      muxnxn_port_out_valid <= 1'b1;
      if (!muxnxn_port_mode) ptr <= ptr_next;
    end else if (muxnxn_port_out_ready) begin
      // Drain with no replacement; data and grant keep their last values.
      muxnxn_port_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_muxnxn_rr.sv
module tb_muxnxn_rr;

  localparam int M  = 16;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int M3 = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*M-1:0]  din;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [M-1:0]    dout;
  logic            ov;
  logic            oready;
  logic [SW-1:0]   grant;

  logic [N3*M3-1:0] din3;
  logic [N3-1:0]    valid3;
  logic [N3-1:0]    ready3;
  logic             mode3;
  logic [1:0]       sel3;
  logic [M3-1:0]    dout3;
  logic             ov3;
  logic             oready3;
  logic [1:0]       grant3;

  muxnxn_rr #(.M(M), .N(N)) dut (
    .muxnxn_port_clk       (clk),
    .muxnxn_port_rst       (rst),
    .muxnxn_port_i         (din),
    .muxnxn_port_valid     (valid),
    .muxnxn_port_ready     (ready),
    .muxnxn_port_mode      (mode),
    .muxnxn_port_sel       (sel),
    .muxnxn_port_out       (dout),
    .muxnxn_port_out_valid (ov),
    .muxnxn_port_out_ready (oready),
    .muxnxn_port_grant     (grant)
  );

  muxnxn_rr #(.M(M3), .N(N3)) dut3 (
    .muxnxn_port_clk       (clk),
    .muxnxn_port_rst       (rst),
    .muxnxn_port_i         (din3),
    .muxnxn_port_valid     (valid3),
    .muxnxn_port_ready     (ready3),
    .muxnxn_port_mode      (mode3),
    .muxnxn_port_sel       (sel3),
    .muxnxn_port_out       (dout3),
    .muxnxn_port_out_valid (ov3),
    .muxnxn_port_out_ready (oready3),
    .muxnxn_port_grant     (grant3)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state for the N=4 instance.
  int         m_ptr   = 0;
  logic [M-1:0] m_out = '0;
  int         m_grant = 0;
  logic       m_ov    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules say should be offered a handshake right now.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int k;
    r = '0;
    if (rst) return r;
    if (m_ov && !oready) return r;
    if (mode) begin
      if (int'(sel) < N && valid[sel]) r[sel] = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        k = (m_ptr + i) % N;
        if (valid[k] && r == '0) r[k] = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs.
  task automatic step();
    logic [N-1:0] er;
    int k;
    #1;
    er = model_ready();
    check("ready", {60'd0, ready}, {60'd0, er});
    @(posedge clk);
    if (rst) begin
      m_ov = 1'b0; m_out = '0; m_grant = 0; m_ptr = 0;
    end else if (er != '0) begin
      k = 0;
      for (int i = 0; i < N; i++) if (er[i]) k = i;
      m_out   = din[k*M +: M];
      m_grant = k;
      m_ov    = 1'b1;
      if (!mode) m_ptr = (k + 1) % N;
    end else if (oready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", {63'd0, ov}, {63'd0, m_ov});
    check("out", {48'd0, dout}, {48'd0, m_out});
    check("grant", {62'd0, grant}, 64'(m_grant));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; valid = 4'hF; oready = 1'b1;
    for (int k = 0; k < N; k++) din[k*M +: M] = 16'hA000 + 16'(k);
    mode3 = 1'b0; sel3 = '0; valid3 = 3'b111; oready3 = 1'b1;
    for (int k = 0; k < N3; k++) din3[k*M3 +: M3] = 8'hB0 + 8'(k);

    // Reset held for two cycles with all inputs active.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_ready", {60'd0, ready}, 64'd0);
      check("rst_out", {48'd0, dout}, 64'd0);
      check("rst_ov", {63'd0, ov}, 64'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_ready", {60'd0, ready}, 64'b0001);

    // Round-robin rotation, and wrap over a non-power-of-two channel count.
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_grant", {62'd0, grant}, 64'(i % 4));
      check("rr_out", {48'd0, dout}, 64'(16'hA000 + 16'(i % 4)));
      check("rr3_grant", {62'd0, grant3}, 64'(i % 3));
    end

    // Sparse valid; meanwhile the N=3 instance moves to fixed mode.
    valid = 4'b1010;
    mode3 = 1'b1; sel3 = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("sparse_grant", {62'd0, grant}, (i % 2 == 0) ? 64'd1 : 64'd3);
      if (i == 0) begin
        check("n3_sel2_grant", {62'd0, grant3}, 64'd2);
        check("n3_sel2_ov", {63'd0, ov3}, 64'd1);
        sel3 = 2'd3;
      end else begin
        check("n3_sel3_ready", {61'd0, ready3}, 64'd0);
        check("n3_sel3_ov", {63'd0, ov3}, 64'd0);
        check("n3_sel3_out", {56'd0, dout3}, 64'hB2);
      end
    end

    // Backpressure: load channel 2, then stall for five cycles.
    valid = 4'b0100;
    step();
    check("bp_load", {48'd0, dout}, 64'hA002);
    oready = 1'b0; valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_out", {48'd0, dout}, 64'hA002);
      check("bp_hold_grant", {62'd0, grant}, 64'd2);
      check("bp_hold_ready", {60'd0, ready}, 64'd0);
    end
    oready = 1'b1;
    step();
    check("bp_nobubble_out", {48'd0, dout}, 64'hA003);
    check("bp_nobubble_ov", {63'd0, ov}, 64'd1);

    // Move ptr to 1, then fixed mode must leave it there.
    valid = 4'hF;
    step();
    check("pre_fix_grant", {62'd0, grant}, 64'd0);
    mode = 1'b1; sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fix_grant", {62'd0, grant}, 64'd2);
    end
    mode = 1'b0;
    step();
    check("fix_ptr_kept", {62'd0, grant}, 64'd1);

    // Fixed select of an idle channel: nothing loads, the register drains.
    mode = 1'b1; sel = 2'd2; valid = 4'b1011;
    step();
    check("fix_idle_ov", {63'd0, ov}, 64'd0);
    step();
    check("fix_idle_ov2", {63'd0, ov}, 64'd0);

    // Reset on a cycle that would otherwise transfer channel 1.
    mode = 1'b0; valid = 4'b0010;
    #1;
    check("mid_pre_ready", {60'd0, ready}, 64'b0010);
    rst = 1'b1;
    step();
    check("mid_rst_out", {48'd0, dout}, 64'd0);
    check("mid_rst_ov", {63'd0, ov}, 64'd0);
    rst = 1'b0; valid = 4'hF;
    step();
    check("mid_rst_restart", {62'd0, grant}, 64'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      mode   = ($urandom_range(0, 3) == 0);
      sel    = 2'($urandom);
      valid  = 4'($urandom);
      oready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) din[k*M +: M] = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
